// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack (call/ret) and optional relative branch.
// Latency: one clock from request to pc_out/sp update; stack_err pulses the cycle after a failed call/ret.
// Backpressure: none. One operation is applied per cycle by fixed priority and lower-priority requests are dropped.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   pc_en                  increment pc by one
//   pc_load, pc_in         absolute jump to pc_in (pc_in is also the call target)
//   call, ret              push return address and jump / pop return address into pc
//   pc_rel, rel_off        relative branch by signed rel_off (only when PC_REL_BRANCH_EN is defined)
//   pc_out                 registered current instruction address
//   sp                     stack occupancy, 0..STACK_DEPTH
//   stack_full/empty       decodes of the registered sp
//   stack_err              registered one-cycle pulse on overflow/underflow attempt
//
// Build option: define PC_REL_BRANCH_EN to enable relative branches. When it is undefined,
// pc_rel and rel_off stay on the port list but are ignored and no branch adder is built.

module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pc_en,
  input  logic                             pc_load,
  input  logic [ADDR_W-1:0]                pc_in,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             pc_rel,
  input  logic [ADDR_W-1:0]                rel_off,
  output logic [ADDR_W-1:0]                pc_out,
  output logic [$clog2(STACK_DEPTH):0]     sp,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  // Operation selected this cycle after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_REL,
    OP_INC
  } op_e;

  op_e               op;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic              err_q;
  logic              err_d;
  logic              push;
  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              rel_req;
  logic [ADDR_W-1:0] rel_target;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // Shared incrementer: feeds both pc_en and the return address pushed by call.
  assign pc_inc = pc_q + ADDR_W'(1);
  assign sp_dec = sp_q - SP_W'(1);

  // Push only happens when not full, so sp fits in the index width; pop only when
  // not empty, so sp-1 is a valid index.
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];

`ifdef PC_REL_BRANCH_EN
  // Two's-complement add; wrap-around gives the signed result modulo 2^ADDR_W.
  assign rel_req    = pc_rel;
  assign rel_target = pc_q + rel_off;
`else
  // Relative branch disabled: the request is treated as absent, so pc_en still
  // applies if asserted alongside it.
  logic unused_rel;
  assign unused_rel = ^{pc_rel, rel_off};
  assign rel_req    = 1'b0;
  assign rel_target = pc_q;
`endif

  // Priority: pc_load > call > ret > pc_rel > pc_en. rst is handled in the register.
  always_comb begin
    op = OP_HOLD;
    if (pc_load) begin
      op = OP_LOAD;
    end else if (call) begin
      op = OP_CALL;
    end else if (ret) begin
      op = OP_RET;
    end else if (rel_req) begin
      op = OP_REL;
    end else if (pc_en) begin
      op = OP_INC;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = 1'b0;
    push  = 1'b0;
    unique case (op)
      OP_LOAD: begin
        pc_d = pc_in;
      end
      OP_CALL: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
          pc_d = pc_in;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_dec;
          pc_d = stack_mem[pop_idx];
        end
      end
      OP_REL: begin
        pc_d = rel_target;
      end
      OP_INC: begin
        pc_d = pc_inc;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_ADDR);
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entry storage needs no reset; contents are only read below sp. A push in the
  // reset cycle is harmless because sp returns to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign pc_out    = pc_q;
  assign sp        = sp_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_en;
  logic       pc_load;
  logic [7:0] pc_in;
  logic       call;
  logic       ret;
  logic       pc_rel;
  logic [7:0] rel_off;
  logic [7:0] pc_out;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(
    .ADDR_W     (8),
    .STACK_DEPTH(4),
    .RESET_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .call       (call),
    .ret        (ret),
    .pc_rel     (pc_rel),
    .rel_off    (rel_off),
    .pc_out     (pc_out),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; pc_en = 1'b0; pc_load = 1'b0; pc_in = 8'h00;
    call = 1'b0; ret = 1'b0; pc_rel = 1'b0; rel_off = 8'h00;
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a);
    idle(); pc_load = 1'b1; pc_in = a; cyc(); idle();
  endtask

  task automatic do_call(input logic [7:0] a);
    idle(); call = 1'b1; pc_in = a; cyc(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1'b1; cyc(); idle();
  endtask

  logic [7:0] ret_exp [4];
  logic [7:0] call_tgt [4];
  logic [7:0] rel_exp;
  logic [7:0] rel_en_exp;

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_pc", pc_out, 8'h00);
    check("rst_sp", sp, 3'd0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_err", stack_err, 1'b0);

    // Increment from reset
    for (int i = 1; i <= 3; i++) begin
      idle(); pc_en = 1'b1; cyc();
      check($sformatf("inc_%0d", i), pc_out, 32'(i));
    end
    idle(); cyc();
    check("hold", pc_out, 8'h03);

    // Wrap at all-ones
    do_load(8'hFF);
    check("load_ff", pc_out, 8'hFF);
    pc_en = 1'b1; cyc(); idle();
    check("wrap", pc_out, 8'h00);
    check("wrap_err", stack_err, 1'b0);

    // Single call / ret
    do_load(8'h10);
    do_call(8'h40);
    check("call_pc", pc_out, 8'h40);
    check("call_sp", sp, 3'd1);
    check("call_empty", stack_empty, 1'b0);
    do_ret();
    check("ret_pc", pc_out, 8'h11);
    check("ret_sp", sp, 3'd0);
    check("ret_empty", stack_empty, 1'b1);

    // Four nested calls, overflow attempt, then unwinding
    call_tgt[0] = 8'h20; call_tgt[1] = 8'h30; call_tgt[2] = 8'h40; call_tgt[3] = 8'h50;
    ret_exp[0]  = 8'h11; ret_exp[1]  = 8'h21; ret_exp[2]  = 8'h31; ret_exp[3]  = 8'h41;
    do_load(8'h10);
    for (int i = 0; i < 4; i++) begin
      do_call(call_tgt[i]);
      check($sformatf("nest_pc_%0d", i), pc_out, call_tgt[i]);
      check($sformatf("nest_sp_%0d", i), sp, 32'(i + 1));
    end
    check("full", stack_full, 1'b1);
    do_call(8'h99);
    check("ovf_pc", pc_out, 8'h50);
    check("ovf_sp", sp, 3'd4);
    check("ovf_err", stack_err, 1'b1);
    cyc();
    check("ovf_err_clr", stack_err, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      do_ret();
      check($sformatf("unwind_pc_%0d", i), pc_out, ret_exp[i]);
      check($sformatf("unwind_sp_%0d", i), sp, 32'(i));
    end
    check("unwind_empty", stack_empty, 1'b1);
    check("unwind_err", stack_err, 1'b0);

    // Underflow
    do_ret();
    check("unf_pc", pc_out, 8'h11);
    check("unf_sp", sp, 3'd0);
    check("unf_err", stack_err, 1'b1);
    cyc();
    check("unf_err_clr", stack_err, 1'b0);

    // pc_load beats call
    idle(); pc_load = 1'b1; call = 1'b1; pc_in = 8'h20; cyc(); idle();
    check("prio_load_pc", pc_out, 8'h20);
    check("prio_load_sp", sp, 3'd0);

    // call beats ret and pc_en
    idle(); call = 1'b1; ret = 1'b1; pc_en = 1'b1; pc_in = 8'h60; cyc(); idle();
    check("prio_call_pc", pc_out, 8'h60);
    check("prio_call_sp", sp, 3'd1);
    // ret beats pc_en
    idle(); ret = 1'b1; pc_en = 1'b1; cyc(); idle();
    check("prio_ret_pc", pc_out, 8'h21);
    check("prio_ret_sp", sp, 3'd0);

    // Relative branch (backwards by 3), alone and together with pc_en
`ifdef PC_REL_BRANCH_EN
    rel_exp    = 8'h02;
    rel_en_exp = 8'h02;
`else
    rel_exp    = 8'h05;
    rel_en_exp = 8'h06;
`endif
    do_load(8'h05);
    idle(); pc_rel = 1'b1; rel_off = 8'hFD; cyc(); idle();
    check("rel_pc", pc_out, rel_exp);
    do_load(8'h05);
    idle(); pc_rel = 1'b1; pc_en = 1'b1; rel_off = 8'hFD; cyc(); idle();
    check("rel_en_pc", pc_out, rel_en_exp);

    // Reset overrides a concurrent call with sp=2
    do_load(8'h30);
    do_call(8'h70);
    do_call(8'h80);
    check("pre_rst_sp", sp, 3'd2);
    idle(); rst = 1'b1; call = 1'b1; pc_in = 8'hAA; cyc(); idle();
    check("rst_call_pc", pc_out, 8'h00);
    check("rst_call_sp", sp, 3'd0);
    check("rst_call_err", stack_err, 1'b0);
    check("rst_call_empty", stack_empty, 1'b1);

    // Reset overrides an overflowing call: no error pulse
    for (int i = 0; i < 4; i++) do_call(call_tgt[i]);
    idle(); rst = 1'b1; call = 1'b1; pc_in = 8'h99; cyc(); idle();
    check("rst_ovf_err", stack_err, 1'b0);
    check("rst_ovf_sp", sp, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the instruction address.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: number of return-address entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_ADDR, default 0: pc_out value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pc_en  input  1  increment pc by 1.
REQ-007 SHALL have port pc_load  input  1  absolute jump to pc_in.
REQ-008 SHALL have port pc_in  input  ADDR_W  absolute jump/call target.
REQ-009 SHALL have port call  input  1  push return address, jump to pc_in.
REQ-010 SHALL have port ret  input  1  pop return address into pc.
REQ-011 SHALL have port pc_rel  input  1  relative branch by rel_off.
REQ-012 SHALL have port rel_off  input  ADDR_W  two's-complement branch offset.
REQ-013 SHALL have port pc_out  output  ADDR_W  current instruction address (registered).
REQ-014 SHALL have port sp  output  clog2(STACK_DEPTH)+1  current stack occupancy.
REQ-015 SHALL have port stack_full  output  1  high when sp == STACK_DEPTH.
REQ-016 SHALL have port stack_empty  output  1  high when sp == 0.
REQ-017 SHALL have port stack_err  output  1  one-cycle pulse on overflow/underflow attempt.

Function
REQ-018 SHALL apply exactly one operation per cycle, priority rst > pc_load > call > ret > pc_rel > pc_en; lower-priority requests in the same cycle are discarded.
REQ-019 pc_load SHALL set pc_out <= pc_in next edge; stack unchanged.
REQ-020 call with stack not full SHALL write (pc_out+1) mod 2^ADDR_W to entry sp, increment sp, set pc_out <= pc_in, all in one edge.
REQ-021 call with stack full SHALL leave pc_out, sp and stack contents unchanged and pulse stack_err for one cycle.
REQ-022 ret with stack not empty SHALL decrement sp and set pc_out <= entry sp-1, same edge.
REQ-023 ret with stack empty SHALL leave pc_out and sp unchanged and pulse stack_err for one cycle.
REQ-024 pc_rel SHALL set pc_out <= (pc_out + rel_off) mod 2^ADDR_W, rel_off treated as signed.
REQ-025 pc_en SHALL set pc_out <= (pc_out + 1) mod 2^ADDR_W; all-ones wraps to 0 without flag.
REQ-026 With no request asserted, pc_out and stack SHALL hold.
REQ-027 stack_full, stack_empty SHALL be combinational decodes of registered sp (no added latency).
REQ-028 stack_err SHALL be registered, asserted the cycle after the failing request, low otherwise.
REQ-029 Stack entries SHALL behave as LIFO; popped entries need not be cleared.

Reset
REQ-030 rst high at a rising edge SHALL set pc_out=RESET_ADDR, sp=0, stack_err=0, overriding any concurrent request, including mid-call/ret sequences.
REQ-031 After reset stack_empty=1, stack_full=0; stack entry contents are don't-care.

Configuration
REQ-032 Macro PC_REL_BRANCH_EN defined: pc_rel/rel_off behave per REQ-024.
REQ-033 Macro PC_REL_BRANCH_EN undefined: ports pc_rel and rel_off remain present but SHALL be ignored (treated as no request); no adder for relative branch synthesised; priority of remaining operations unchanged.

Verification
REQ-034 Reset then 3 cycles pc_en=1 -> pc_out 0,1,2,3; with pc_out=8'hFF, pc_en -> 8'h00.
REQ-035 pc_out=8'h10, call pc_in=8'h40 -> pc_out=8'h40, sp=1; then ret -> pc_out=8'h11, sp=0, stack_empty=1.
REQ-036 Four nested calls (depth 4) -> stack_full=1; fifth call pc_in=8'h99 -> pc_out unchanged, sp=4, stack_err pulses one cycle; four rets return in reverse order.
REQ-037 ret with sp=0 -> pc_out unchanged, stack_err pulse; pc_load=1 with call=1, pc_in=8'h20 -> pc_out=8'h20, sp unchanged.
REQ-038 PC_REL_BRANCH_EN defined: pc_out=8'h05, pc_rel rel_off=8'hFD -> pc_out=8'h02; macro undefined: same stimulus -> pc_out holds 8'h05.
REQ-039 rst asserted same cycle as call with sp=2 -> pc_out=RESET_ADDR, sp=0, stack_err=0.
